// File: rtl/mplr_shift_reg.sv
// rtl/mplr_shift_reg.sv - multiplier shift register for shift-add multiply cells
//
// Loads a WIDTH-bit multiplier operand through a ld_valid/ld_ready handshake,
// then shifts it right one bit per sft cycle. The vacated MSB is filled with
// s_in (logical mode) or a copy of the MSB (arithmetic mode, chosen at load).
// After exactly WIDTH shifts the block pulses done for one cycle and then
// returns to IDLE, where it can accept the next operand.
//
// Optional feature macro: BOOTH_EN
//   defined   - adds the q_m1 flop (previous lsb); booth_op = {data_out[0], q_m1}
//   undefined - no q_m1 flop; booth_op is tied to 2'b00
//
// Ports:
//   clk       rising-edge clock
//   clr       synchronous active-high clear, priority over load and shift
//   ld_valid  load request
//   ld_ready  block can accept a load (IDLE and clr low)
//   data_in   operand to load
//   arith     sampled on load: 1 = arithmetic shift, s_in ignored
//   sft       shift enable (honoured only while shifting)
//   s_in      serial bit inserted at the MSB in logical mode
//   data_out  register contents
//   lsb       data_out[0]
//   booth_op  radix-2 Booth pair {data_out[0], q_m1}
//   count     shifts remaining
//   busy      high while shifting
//   done      one-cycle completion pulse

module mplr_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             arith,
    input  logic             sft,
    input  logic             s_in,
    output logic [WIDTH-1:0] data_out,
    output logic             lsb,
    output logic [1:0]       booth_op,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    logic   mode;
    logic   fill;
    logic   shift_en;

    // Bit entering the MSB on a shift edge.
    assign fill     = mode ? data_out[WIDTH-1] : s_in;
    assign shift_en = (state == SHIFT) && sft;

    // clr gates ld_ready so a handshake can never complete in a clear cycle.
    assign ld_ready = (state == IDLE) && !clr;
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);
    assign lsb      = data_out[0];

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            data_out <= '0;
            count    <= '0;
            mode     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_valid) begin
                        data_out <= data_in;
                        count    <= CNT_W'(WIDTH);
                        mode     <= arith;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sft) begin
                        data_out <= {fill, data_out[WIDTH-1:1]};
                        count    <= count - CNT_W'(1);
                        if (count == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BOOTH_EN
    logic q_m1;

    // q_m1 holds the bit shifted out on the previous edge, so the pair
    // {data_out[0], q_m1} is the Booth recoding for the coming edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_m1 <= 1'b0;
        end else if (ld_ready && ld_valid) begin
            q_m1 <= 1'b0;
        end else if (shift_en) begin
            q_m1 <= data_out[0];
        end
    end

    assign booth_op = {data_out[0], q_m1};
`else
    logic unused_shift_en;

    assign unused_shift_en = shift_en;
    assign booth_op        = 2'b00;
`endif

endmodule

// File: tb/tb_mplr_shift_reg.sv
// tb/tb_mplr_shift_reg.sv - self-checking bench for mplr_shift_reg

module tb_mplr_shift_reg;

    localparam int W     = 8;
    localparam int CW    = $clog2(W + 1);
    localparam int HALF  = 1 << (W - 1);

    logic          clk = 1'b0;
    logic          clr;
    logic          ld_valid;
    logic          ld_ready;
    logic [W-1:0]  data_in;
    logic          arith;
    logic          sft;
    logic          s_in;
    logic [W-1:0]  data_out;
    logic          lsb;
    logic [1:0]    booth_op;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mplr_shift_reg #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .data_in  (data_in),
        .arith    (arith),
        .sft      (sft),
        .s_in     (s_in),
        .data_out (data_out),
        .lsb      (lsb),
        .booth_op (booth_op),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    // Behavioural model: an operand value, a shifts-remaining number and two
    // flags (operation in progress, completion cycle).
    int unsigned m_data   = 0;
    int          m_left   = 0;
    bit          m_active = 1'b0;
    bit          m_donef  = 1'b0;
    bit          m_arith  = 1'b0;
    bit          m_prev   = 1'b0;

    always @(posedge clk) begin
        if (clr) begin
            m_data = 0; m_left = 0; m_active = 0; m_donef = 0; m_arith = 0; m_prev = 0;
        end else if (m_donef) begin
            m_donef = 0;
        end else if (m_active) begin
            if (sft) begin
                bit top;
                top    = m_arith ? (m_data >= HALF) : s_in;
                m_prev = m_data[0];
                m_data = m_data / 2 + (top ? HALF : 0);
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_active = 0;
                    m_donef  = 1;
                end
            end
        end else if (ld_valid) begin
            m_data   = data_in;
            m_left   = W;
            m_arith  = arith;
            m_prev   = 0;
            m_active = 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [1:0] exp_booth;
`ifdef BOOTH_EN
            exp_booth = {m_data[0], m_prev};
`else
            exp_booth = 2'b00;
`endif
            check("model data_out", 32'(data_out), m_data);
            check("model count",    32'(count),    32'(m_left));
            check("model busy",     32'(busy),     32'(m_active));
            check("model done",     32'(done),     32'(m_donef));
            check("model ld_ready", 32'(ld_ready), 32'(!m_active && !m_donef && !clr));
            check("model lsb",      32'(lsb),      32'(m_data[0]));
            check("model booth_op", 32'(booth_op), 32'(exp_booth));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] lsbs;
        logic [1:0]   bseq [4];
        logic [1:0]   bexp [4];
        logic [W-1:0] hold;
        int           stall [4];
        int           stall_cnt [4];

        // Reset with load and shift requests asserted: nothing may be taken.
        clr = 1; ld_valid = 1; sft = 1; data_in = 8'h5A; arith = 0; s_in = 0;
        step();
        chk_en = 1'b1;
        step();
        clr = 0; ld_valid = 0; sft = 0;
        #1;
        check("reset data_out", 32'(data_out), 32'h00);
        check("reset count",    32'(count),    32'd0);
        check("reset busy",     32'(busy),     32'd0);
        check("reset done",     32'(done),     32'd0);
        check("reset ld_ready", 32'(ld_ready), 32'd1);
        step();

        // Logical shift of 0xB5, back-to-back.
        data_in = 8'hB5; arith = 0; s_in = 0; ld_valid = 1;
        step();
        ld_valid = 0;
        check("load busy",  32'(busy),  32'd1);
        check("load count", 32'(count), 32'd8);
        sft = 1;
        for (int i = 0; i < W; i++) begin
            lsbs[i] = lsb;
            step();
        end
        check("logical lsb sequence", 32'(lsbs), 32'hB5);
        check("logical final data",   32'(data_out), 32'h00);
        check("logical done pulse",   32'(done), 32'd1);
        step();
        check("logical done cleared", 32'(done), 32'd0);
        check("logical ld_ready back", 32'(ld_ready), 32'd1);
        sft = 0;
        step();

        // Arithmetic shift of 0x80.
        data_in = 8'h80; arith = 1; ld_valid = 1;
        step();
        ld_valid = 0; arith = 0; sft = 1;
        repeat (3) step();
        check("arith data after 3", 32'(data_out), 32'hF0);
        check("arith count after 3", 32'(count), 32'd5);
        repeat (5) step();
        check("arith final data", 32'(data_out), 32'hFF);
        check("arith done pulse", 32'(done), 32'd1);
        sft = 0;
        step();

        // Stalls with ld_valid held high during SHIFT.
        data_in = 8'h0F; ld_valid = 1;
        step();
        check("stall start count", 32'(count), 32'd8);
        stall     = '{1, 0, 0, 1};
        stall_cnt = '{7, 7, 7, 6};
        for (int i = 0; i < 4; i++) begin
            sft = stall[i][0];
            step();
            check("stall count", 32'(count), 32'(stall_cnt[i]));
            check("stall ld_ready", 32'(ld_ready), 32'd0);
        end
        check("stall no reload", 32'(data_out), 32'h03);
        ld_valid = 0; s_in = 1; sft = 1;
        repeat (6) step();
        check("stall final data", 32'(data_out), 32'hFC);
        hold = data_out;
        step();
        check("sft ignored in DONE->IDLE", 32'(data_out), 32'(hold));
        step();
        check("sft ignored in IDLE", 32'(data_out), 32'(hold));
        sft = 0; s_in = 0;

        // Clear in the middle of an operation.
        data_in = 8'hAA; ld_valid = 1;
        step();
        ld_valid = 0; sft = 1;
        repeat (3) step();
        check("pre-clr data", 32'(data_out), 32'h15);
        sft = 0; clr = 1;
        step();
        clr = 0;
        check("mid clr data",  32'(data_out), 32'h00);
        check("mid clr count", 32'(count), 32'd0);
        check("mid clr busy",  32'(busy), 32'd0);
        step();
        check("mid clr no done", 32'(done), 32'd0);
        data_in = 8'h55; ld_valid = 1;
        step();
        ld_valid = 0;
        check("reload data", 32'(data_out), 32'h55);
        check("reload busy", 32'(busy), 32'd1);
        sft = 1;
        repeat (8) step();
        check("reload done", 32'(done), 32'd1);
        sft = 0;
        step();

        // Booth pair sequence for 0x06.
        data_in = 8'h06; s_in = 0; ld_valid = 1;
        step();
        ld_valid = 0; sft = 1;
        for (int i = 0; i < 4; i++) begin
            bseq[i] = booth_op;
            step();
        end
`ifdef BOOTH_EN
        bexp = '{2'b00, 2'b10, 2'b11, 2'b01};
`else
        bexp = '{2'b00, 2'b00, 2'b00, 2'b00};
`endif
        for (int i = 0; i < 4; i++) begin
            check("booth pair", 32'(bseq[i]), 32'(bexp[i]));
        end
        check("booth after 4th", 32'(booth_op), 32'd0);
        repeat (4) step();
        check("booth done", 32'(done), 32'd1);
        sft = 0;
        repeat (3) step();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
